// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_RUN    = 2'd1,
        PC_HALTED = 2'd2
    } pc_state_e;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int unsigned PC_STEP    = 32'd4;
    // Low PC bits that must be zero for a legal fetch address.
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // True when the two low address bits describe a word-aligned target.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return ((lsb & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/pc_hist_buf.sv
// Circular history of recently issued PCs; index 0 reads the newest entry.
module pc_hist_buf
    import pc_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [XLEN-1:0]               push_pc_i,
    input  logic [$clog2(HIST_DEPTH)-1:0] idx_i,
    output logic [XLEN-1:0]               hist_pc_o,
    output logic [$clog2(HIST_DEPTH):0]   hist_cnt_o
);

    localparam int PW = $clog2(HIST_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [HIST_DEPTH];
    logic [XLEN-1:0] mem_d [HIST_DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   wptr_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   rd_ptr_s;

    // Next-state for the buffer: write at the pointer, advance, saturate the count.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (push_i) begin
            mem_d[wptr_q] = push_pc_i;
            wptr_d        = wptr_q + PW'(1);
            if (cnt_q != CW'(HIST_DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            wptr_d = wptr_q;
        end
    end

    // Buffer storage, write pointer and fill count; cleared on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read entry counted back from the newest; unfilled slots read as zero.
    always_comb begin
        rd_ptr_s = wptr_q - PW'(1) - idx_i;
        if (CW'(idx_i) < cnt_q) begin
            hist_pc_o = mem_q[rd_ptr_s];
        end else begin
            hist_pc_o = '0;
        end
    end

    assign hist_cnt_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: boot vector select, sequential step, redirect,
// debug halt/resume and a short history of issued PCs.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                               XLEN       = 32,
    parameter int                               NUM_BOOT   = 2,
    parameter logic [NUM_BOOT-1:0][XLEN-1:0]    BOOT_ADDRS = {32'h8000_0000, 32'h0000_0000},
    parameter int                               HIST_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [$clog2(NUM_BOOT)-1:0]   boot_sel_i,
    input  logic                          stall_i,
    input  logic                          redirect_i,
    input  logic [XLEN-1:0]               redirect_pc_i,
    input  logic                          halt_req_i,
    input  logic                          resume_i,
    input  logic [XLEN-1:0]               resume_pc_i,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
    output logic [XLEN-1:0]               pc_o,
    output logic                          pc_valid_o,
    output logic                          halted_o,
    output logic                          misalign_o,
    output logic [XLEN-1:0]               hist_pc_o,
    output logic [$clog2(HIST_DEPTH):0]   hist_cnt_o
);

    localparam logic [XLEN-1:0] LOW_MASK = {{(XLEN-2){1'b0}}, ALIGN_MASK};

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_valid_q;
    logic            pc_valid_d;
    logic            halted_q;
    logic            halted_d;
    logic            misalign_q;
    logic            misalign_d;
    logic            push_s;

    // Next-PC mux and state transitions; redirect outranks halt and stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        push_s     = 1'b0;
        case (state_q)
            PC_BOOT: begin
                if (int'(boot_sel_i) < NUM_BOOT) begin
                    pc_d = BOOT_ADDRS[boot_sel_i];
                end else begin
                    pc_d = BOOT_ADDRS[0];
                end
                state_d = PC_RUN;
            end
            PC_RUN: begin
                if (redirect_i && !is_aligned(redirect_pc_i[1:0])) begin
                    misalign_d = 1'b1;
                    state_d    = PC_HALTED;
                end else if (redirect_i) begin
                    pc_d   = redirect_pc_i;
                    push_s = 1'b1;
                end else if (halt_req_i && !stall_i) begin
                    state_d = PC_HALTED;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d   = pc_q + XLEN'(PC_STEP);
                    push_s = 1'b1;
                end
            end
            PC_HALTED: begin
                if (resume_i) begin
                    pc_d    = resume_pc_i & ~LOW_MASK;
                    state_d = PC_RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = PC_BOOT;
                pc_d    = '0;
            end
        endcase
        pc_valid_d = (state_d == PC_RUN);
        halted_d   = (state_d == PC_HALTED);
    end

    // FSM state, PC and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PC_BOOT;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    pc_hist_buf #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_s),
        .push_pc_i  (pc_q),
        .idx_i      (hist_idx_i),
        .hist_pc_o  (hist_pc_o),
        .hist_cnt_o (hist_cnt_o)
    );

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign halted_o   = halted_q;
    assign misalign_o = misalign_q;

endmodule
